// File: rtl/dsm_ctrl_pkg.sv
// Shared types and constants for the delta-sigma modulator sequencing controller.
package dsm_ctrl_pkg;

   localparam int SAMPLE_W = 20;
   localparam int GAIN_W   = 9;

   typedef logic [SAMPLE_W-1:0] sample_t;

   // +1.0 V in modulator input units
   localparam sample_t VIN_FS = 20'h0_8000;

   // Gain value that passes the clamped sample through unchanged
   localparam int unsigned GAIN_FULL = 256;

   typedef enum logic [2:0] {
      STATE_IDLE      = 3'd0,
      STATE_CLEAR     = 3'd1,
      STATE_RAMP_UP   = 3'd2,
      STATE_RUN       = 3'd3,
      STATE_RAMP_DOWN = 3'd4,
      STATE_RECOVER   = 3'd5
   } dsm_state_e;

   // Plain vector codes for the state register
   localparam logic [2:0] ST_IDLE      = STATE_IDLE;
   localparam logic [2:0] ST_CLEAR     = STATE_CLEAR;
   localparam logic [2:0] ST_RAMP_UP   = STATE_RAMP_UP;
   localparam logic [2:0] ST_RUN       = STATE_RUN;
   localparam logic [2:0] ST_RAMP_DOWN = STATE_RAMP_DOWN;
   localparam logic [2:0] ST_RECOVER   = STATE_RECOVER;

   // States in which the modulator is held in reset and its input is forced to zero
   function automatic logic holds_dsm_reset(input logic [2:0] st);
      return (st == ST_IDLE) || (st == ST_CLEAR) || (st == ST_RECOVER);
   endfunction

   // States in which samples are streamed and the slot counter runs
   function automatic logic is_streaming(input logic [2:0] st);
      return (st == ST_RAMP_UP) || (st == ST_RUN) || (st == ST_RAMP_DOWN);
   endfunction

endpackage

// File: rtl/dsm_gain_scale.sv
// Combinational amplitude clamp followed by gain multiply and shift by 8.
// Gain 256 returns the clamped sample exactly, gain 0 returns zero.
module dsm_gain_scale
   import dsm_ctrl_pkg::*;
#(
   parameter sample_t MAX_AMP = 20'h0_6000
) (
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [GAIN_W-1:0]   gain,
   output logic [SAMPLE_W-1:0] scaled
);

   logic signed [SAMPLE_W-1:0] sample_s;
   logic signed [SAMPLE_W-1:0] limit_pos;
   logic signed [SAMPLE_W-1:0] limit_neg;
   logic signed [SAMPLE_W-1:0] clamped;
   logic signed [28:0]         product;

   // Saturate to +/-MAX_AMP, multiply by the unsigned gain, keep product bits [27:8]
   always_comb begin
      sample_s  = $signed(sample);
      limit_pos = $signed(MAX_AMP);
      limit_neg = -limit_pos;
      if (sample_s > limit_pos) begin
         clamped = limit_pos;
      end else if (sample_s < limit_neg) begin
         clamped = limit_neg;
      end else begin
         clamped = sample_s;
      end
      product = 29'(clamped) * 29'($signed({1'b0, gain}));
      scaled  = 20'(product >>> 8);
   end

endmodule

// File: rtl/dsm_ctrl.sv
// Sequencing controller in front of the 20-bit delta-sigma modulator: streams
// samples at one per OSR clocks, soft-ramps gain on enable/disable, drives the
// modulator reset and restarts the ramp when the pwm output gets stuck.
module dsm_ctrl
   import dsm_ctrl_pkg::*;
#(
   parameter int unsigned OSR         = 64,
   parameter int unsigned CLR_CYCLES  = 8,
   parameter int unsigned STUCK_LIMIT = 64,
   parameter int unsigned RAMP_STEP   = 1,
   parameter sample_t     MAX_AMP     = VIN_FS - (VIN_FS >> 2)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                s_ready,
   input  logic                pwm,
   output logic                dsm_rst,
   output logic [SAMPLE_W-1:0] dsm_vin,
   output logic [2:0]          state,
   output logic                overload,
   output logic                underrun
);

   localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
   localparam int STK_W = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OSR - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);
   localparam logic [STK_W-1:0]  STK_LAST = STK_W'(STUCK_LIMIT - 1);
   localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(GAIN_FULL);

   logic [2:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CLR_W-1:0]    clr_q, clr_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic [GAIN_W-1:0]   gain_up, gain_dn;
   logic [31:0]         up_sum;
   logic [SAMPLE_W-1:0] held_q;
   logic [SAMPLE_W-1:0] scaled;
   logic [STK_W-1:0]    stuck_q;
   logic                pwm_prev_q;
   logic                active;
   logic                slot;
   logic                stuck_hit;

   assign active    = is_streaming(state_q);
   assign slot      = active && (cnt_q == CNT_LAST);
   assign stuck_hit = active && (pwm == pwm_prev_q) && (stuck_q == STK_LAST);

   assign s_ready = slot;
   assign dsm_rst = holds_dsm_reset(state_q);
   assign state   = state_q;

   // Saturating gain step values for the next slot edge
   always_comb begin
      up_sum  = 32'(gain_q) + 32'(RAMP_STEP);
      gain_up = (up_sum >= 32'(GAIN_FULL)) ? GAIN_MAX : up_sum[GAIN_W-1:0];
      gain_dn = (32'(gain_q) <= 32'(RAMP_STEP)) ? '0 : gain_q - GAIN_W'(RAMP_STEP);
   end

   // Next-state, slot counter, clear-phase counter and gain
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      clr_d   = '0;
      cnt_d   = slot ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
         ST_IDLE: begin
            gain_d = '0;
            cnt_d  = '0;
            if (enable) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            gain_d = '0;
            cnt_d  = '0;
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (clr_q == CLR_LAST) begin
               state_d = ST_RAMP_UP;
            end else begin
               clr_d = clr_q + CLR_W'(1);
            end
         end
         ST_RAMP_UP, ST_RUN: begin
            if (stuck_hit) begin
               state_d = ST_RECOVER;
               gain_d  = '0;
               cnt_d   = '0;
            end else if (!enable) begin
               state_d = ST_RAMP_DOWN;
               cnt_d   = '0;
            end else if (slot && (state_q == ST_RAMP_UP)) begin
               gain_d = gain_up;
               if (gain_up == GAIN_MAX) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end
            end
         end
         ST_RAMP_DOWN: begin
            if (stuck_hit) begin
               state_d = ST_RECOVER;
               gain_d  = '0;
               cnt_d   = '0;
            end else if (enable) begin
               state_d = ST_RAMP_UP;
               cnt_d   = '0;
            end else if (slot) begin
               gain_d = gain_dn;
               if (gain_dn == '0) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         ST_RECOVER: begin
            gain_d = '0;
            cnt_d  = '0;
            if (clr_q == CLR_LAST) begin
               state_d = enable ? ST_RAMP_UP : ST_IDLE;
            end else begin
               clr_d = clr_q + CLR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gain_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM, counters and gain registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         clr_q   <= '0;
         gain_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clr_q   <= clr_d;
         gain_q  <= gain_d;
      end
   end

   // Held sample: loaded on a slot transfer, kept on underrun, cleared while idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         held_q   <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= slot && !s_valid;
         if (state_q == ST_IDLE) begin
            held_q <= '0;
         end else if (slot && s_valid) begin
            held_q <= s_data;
         end
      end
   end

   // Stuck-loop detector: run length of unchanged pwm while streaming
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm_prev_q <= 1'b0;
         stuck_q    <= '0;
      end else begin
         pwm_prev_q <= pwm;
         if (!active || stuck_hit) begin
            stuck_q <= '0;
         end else if (pwm == pwm_prev_q) begin
            stuck_q <= stuck_q + STK_W'(1);
         end else begin
            stuck_q <= '0;
         end
      end
   end

   dsm_gain_scale #(
      .MAX_AMP (MAX_AMP)
   ) u_gain_scale (
      .sample (held_q),
      .gain   (gain_q),
      .scaled (scaled)
   );

   // Registered modulator input, zero whenever the modulator is (or is about to be) held in reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dsm_vin  <= '0;
         overload <= 1'b0;
      end else begin
         dsm_vin  <= (holds_dsm_reset(state_q) || holds_dsm_reset(state_d)) ? '0 : scaled;
         overload <= (state_d == ST_RECOVER) && (state_q != ST_RECOVER);
      end
   end

endmodule

// File: tb/tb_dsm_ctrl.sv
// Scenario bench for dsm_ctrl with small parameters (OSR=4, CLR_CYCLES=2,
// STUCK_LIMIT=16, RAMP_STEP=64). Expected modulator inputs are queued when a
// slot is driven and compared when the registered output appears.
module tb_dsm_ctrl;

   localparam int OSR         = 4;
   localparam int CLR_CYCLES  = 2;
   localparam int STUCK_LIMIT = 16;
   localparam int RAMP_STEP   = 64;
   localparam int WAIT_BOUND  = 2 * OSR + CLR_CYCLES + 8;

   logic        clock    = 1'b0;
   logic        reset    = 1'b1;
   logic        enable   = 1'b0;
   logic        s_valid  = 1'b0;
   logic [19:0] s_data   = '0;
   logic        pwm      = 1'b0;
   logic        pwm_hold = 1'b0;
   logic        s_ready;
   logic        dsm_rst;
   logic [19:0] dsm_vin;
   logic [2:0]  state;
   logic        overload;
   logic        underrun;

   int n_vec = 0;
   int n_err = 0;
   logic [19:0] exp_q[$];

   dsm_ctrl #(
      .OSR         (OSR),
      .CLR_CYCLES  (CLR_CYCLES),
      .STUCK_LIMIT (STUCK_LIMIT),
      .RAMP_STEP   (RAMP_STEP)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .pwm      (pwm),
      .dsm_rst  (dsm_rst),
      .dsm_vin  (dsm_vin),
      .state    (state),
      .overload (overload),
      .underrun (underrun)
   );

   // 100 MHz clock
   always #5 clock = ~clock;

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock step; pwm toggles every clock unless held high
   task automatic tick();
      @(posedge clock);
      #1;
      pwm = pwm_hold ? 1'b1 : ~pwm;
   endtask

   // Wait for the slot, offer one sample, check underrun and the resulting dsm_vin
   task automatic do_slot(input logic valid, input logic [19:0] data,
                          input logic [19:0] exp_vin, input logic exp_under,
                          input string tag);
      int waited = 0;
      logic [19:0] exp_v;
      while (!s_ready && waited < WAIT_BOUND) begin
         tick();
         waited++;
      end
      n_vec++;
      if (s_ready !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL %s_slot_wait: s_ready=%b after %0d clocks, required 1", tag, s_ready, waited);
         return;
      end
      s_valid = valid;
      s_data  = data;
      exp_q.push_back(exp_vin);
      tick();
      s_valid = 1'b0;
      n_vec++;
      if (underrun !== exp_under) begin
         n_err++;
         $display("[TB] FAIL %s_underrun: got %b, required %b", tag, underrun, exp_under);
      end
      tick();
      exp_v = exp_q.pop_front();
      n_vec++;
      if (dsm_vin !== exp_v) begin
         n_err++;
         $display("[TB] FAIL %s_vin: got %h, required %h", tag, dsm_vin, exp_v);
      end
   endtask

   task automatic test_reset();
      logic saw_ready = 1'b0;
      #2 reset = 1'b0;
      repeat (3) tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL reset_state: got %0d, required 0", state); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL reset_dsm_rst: got %b, required 1", dsm_rst); end
      n_vec++; if (dsm_vin !== 20'h0) begin n_err++; $display("[TB] FAIL reset_vin: got %h, required 00000", dsm_vin); end
      n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_s_ready: got %b, required 0", s_ready); end
      n_vec++; if (overload !== 1'b0) begin n_err++; $display("[TB] FAIL reset_overload: got %b, required 0", overload); end
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("[TB] FAIL reset_underrun: got %b, required 0", underrun); end
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_ready === 1'b1) saw_ready = 1'b1;
      end
      n_vec++; if (saw_ready !== 1'b0) begin n_err++; $display("[TB] FAIL idle_s_ready: got %b, required 0", saw_ready); end
      n_vec++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL idle_state: got %0d, required 0", state); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL idle_dsm_rst: got %b, required 1", dsm_rst); end
      n_vec++; if (dsm_vin !== 20'h0) begin n_err++; $display("[TB] FAIL idle_vin: got %h, required 00000", dsm_vin); end
   endtask

   task automatic test_ramp_up();
      int n = 0;
      enable = 1'b1;
      tick();
      n_vec++; if (state !== 3'd1) begin n_err++; $display("[TB] FAIL clear_state: got %0d, required 1", state); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL clear_dsm_rst: got %b, required 1", dsm_rst); end
      tick();
      tick();
      n_vec++; if (dsm_rst !== 1'b0) begin n_err++; $display("[TB] FAIL rampup_dsm_rst: got %b, required 0", dsm_rst); end
      n_vec++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL rampup_state: got %0d, required 2", state); end
      while (!s_ready && n < WAIT_BOUND) begin
         tick();
         n++;
      end
      n_vec++; if (n != OSR - 1) begin n_err++; $display("[TB] FAIL first_slot_delay: got %0d clocks, required %0d", n, OSR - 1); end
      do_slot(1'b1, 20'h0_4000, 20'h0_1000, 1'b0, "ramp1");
      do_slot(1'b1, 20'h0_4000, 20'h0_2000, 1'b0, "ramp2");
      do_slot(1'b1, 20'h0_4000, 20'h0_3000, 1'b0, "ramp3");
      do_slot(1'b1, 20'h0_4000, 20'h0_4000, 1'b0, "ramp4");
      n_vec++; if (state !== 3'd3) begin n_err++; $display("[TB] FAIL run_state: got %0d, required 3", state); end
   endtask

   task automatic test_clamp();
      do_slot(1'b1, 20'h0_8000, 20'h0_6000, 1'b0, "clamp_pos");
      do_slot(1'b1, 20'hF_8000, 20'hF_A000, 1'b0, "clamp_neg");
      do_slot(1'b1, 20'hF_F000, 20'hF_F000, 1'b0, "pass_neg");
   endtask

   task automatic test_underrun();
      do_slot(1'b0, 20'h0_1234, 20'hF_F000, 1'b1, "underrun");
      n_vec++; if (underrun !== 1'b0) begin n_err++; $display("[TB] FAIL underrun_pulse: got %b one clock later, required 0", underrun); end
   endtask

   task automatic test_overload();
      int n = 0;
      while (pwm !== 1'b1 && n < 4) begin
         tick();
         n++;
      end
      pwm_hold = 1'b1;
      tick();
      n = 0;
      while (overload !== 1'b1 && n < 3 * STUCK_LIMIT) begin
         tick();
         n++;
      end
      n_vec++; if (n != STUCK_LIMIT) begin n_err++; $display("[TB] FAIL overload_delay: got %0d clocks, required %0d", n, STUCK_LIMIT); end
      n_vec++; if (state !== 3'd5) begin n_err++; $display("[TB] FAIL recover_state: got %0d, required 5", state); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL recover_dsm_rst: got %b, required 1", dsm_rst); end
      n_vec++; if (dsm_vin !== 20'h0) begin n_err++; $display("[TB] FAIL recover_vin: got %h, required 00000", dsm_vin); end
      pwm_hold = 1'b0;
      tick();
      n_vec++; if (overload !== 1'b0) begin n_err++; $display("[TB] FAIL overload_pulse: got %b, required 0", overload); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL recover_dsm_rst2: got %b, required 1", dsm_rst); end
      tick();
      n_vec++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL recover_exit_state: got %0d, required 2", state); end
      n_vec++; if (dsm_rst !== 1'b0) begin n_err++; $display("[TB] FAIL recover_exit_dsm_rst: got %b, required 0", dsm_rst); end
      do_slot(1'b1, 20'h0_4000, 20'h0_1000, 1'b0, "restart1");
   endtask

   task automatic test_ramp_down();
      do_slot(1'b1, 20'h0_4000, 20'h0_2000, 1'b0, "restart2");
      enable = 1'b0;
      tick();
      n_vec++; if (state !== 3'd4) begin n_err++; $display("[TB] FAIL rampdown_state: got %0d, required 4", state); end
      do_slot(1'b1, 20'h0_4000, 20'h0_1000, 1'b0, "down1");
      do_slot(1'b1, 20'h0_4000, 20'h0_0000, 1'b0, "down2");
      n_vec++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL down_idle_state: got %0d, required 0", state); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL down_idle_dsm_rst: got %b, required 1", dsm_rst); end
   endtask

   task automatic test_resume();
      int n = 0;
      enable = 1'b1;
      while (state !== 3'd2 && n < WAIT_BOUND) begin
         tick();
         n++;
      end
      n_vec++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL resume_start_state: got %0d, required 2", state); end
      do_slot(1'b1, 20'h0_4000, 20'h0_1000, 1'b0, "resume_up1");
      do_slot(1'b1, 20'h0_4000, 20'h0_2000, 1'b0, "resume_up2");
      enable = 1'b0;
      tick();
      n_vec++; if (state !== 3'd4) begin n_err++; $display("[TB] FAIL resume_down_state: got %0d, required 4", state); end
      do_slot(1'b1, 20'h0_4000, 20'h0_1000, 1'b0, "resume_down1");
      enable = 1'b1;
      tick();
      n_vec++; if (state !== 3'd2) begin n_err++; $display("[TB] FAIL resume_up_state: got %0d, required 2", state); end
      do_slot(1'b1, 20'h0_4000, 20'h0_2000, 1'b0, "resume_up3");
      do_slot(1'b1, 20'h0_4000, 20'h0_3000, 1'b0, "resume_up4");
   endtask

   task automatic test_async_reset();
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      n_vec++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL areset_state: got %0d, required 0", state); end
      n_vec++; if (dsm_rst !== 1'b1) begin n_err++; $display("[TB] FAIL areset_dsm_rst: got %b, required 1", dsm_rst); end
      n_vec++; if (dsm_vin !== 20'h0) begin n_err++; $display("[TB] FAIL areset_vin: got %h, required 00000", dsm_vin); end
      n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL areset_s_ready: got %b, required 0", s_ready); end
      enable = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL areset_release_state: got %0d, required 0", state); end
   endtask

   task automatic test_clear_abort();
      enable = 1'b1;
      tick();
      n_vec++; if (state !== 3'd1) begin n_err++; $display("[TB] FAIL abort_clear_state: got %0d, required 1", state); end
      enable = 1'b0;
      tick();
      n_vec++; if (state !== 3'd0) begin n_err++; $display("[TB] FAIL abort_idle_state: got %0d, required 0", state); end
      n_vec++; if (dsm_vin !== 20'h0) begin n_err++; $display("[TB] FAIL abort_vin: got %h, required 00000", dsm_vin); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_ramp_up();
      test_clamp();
      test_underrun();
      test_overload();
      test_ramp_down();
      test_resume();
      test_async_reset();
      test_clear_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
